// File: rtl/piso_shift_reg.sv
// ============================================================================
// Module   : piso_shift_reg
// Brief    : Parallel-in serial-out shift register with valid/ready load and
//            gapless back-to-back streaming on a shared shift strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int   N          = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);

    localparam int            c_CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_sreg,  w_sreg_nxt;
    logic [c_CW-1:0]  r_cnt,   w_cnt_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_last;

    // Final enabled bit of the current word; the next word may load here.
    assign w_last = (r_state == S_SHIFT) && ena && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_sreg_nxt  = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ena) begin
                    if (r_cnt == c_LAST) begin
                        w_done_nxt = 1'b1;
                        if (in_valid) begin
                            w_sreg_nxt = in_data;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_sreg_nxt = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
                        w_cnt_nxt  = r_cnt + c_CW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE) || w_last;
    assign busy      = (r_state == S_SHIFT);
    assign out_valid = (r_state == S_SHIFT);
    assign out       = (r_state == S_SHIFT) ? (MSB_FIRST ? r_sreg[N-1] : r_sreg[0])
                                            : IDLE_LEVEL;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parallel-in, serial-out shift register. It is the transmit-side counterpart of the team's serial-in parallel-out shift register. It accepts an N-bit word over a valid/ready handshake and shifts it out one bit per enabled clock. With MSB_FIRST=1, a SIPO receiver of the same N, clocked on the same ena, reconstructs the word unchanged on its parallel output. Sits at the edge of serial links such as SPI-like or bit-banged buses, driven by a baud or strobe enable.

Parameters:
N, 8, word width in bits; legal range N >= 1.
MSB_FIRST, 1, 1 = bit N-1 is transmitted first; 0 = bit 0 is transmitted first.
IDLE_LEVEL, 1'b0, value driven on out when no word is being shifted.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low.
ena  input  1  shift strobe; one bit advances per clk edge where ena=1.
in_data  input  N  parallel word; sampled only on handshake.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word this cycle.
out  output  1  serial data bit.
out_valid  output  1  out carries a word bit (high for the whole word).
busy  output  1  a word is loaded and not yet fully shifted.
done  output  1  one-cycle pulse after the final bit of a word is shifted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sreg=0, cnt=0, done=0, out=IDLE_LEVEL, out_valid=0, busy=0.
  - An in-flight word is discarded and no done pulse is issued.
  - Handshakes while rst=0 are ignored.
- Storage:
  - sreg[N-1:0].
  - cnt has width max(1, $clog2(N)) and counts bits already shifted.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready=1, out=IDLE_LEVEL, out_valid=0, busy=0.
  - On in_valid=1: sreg<=in_data, cnt<=0, go to SHIFT.
  - ena is ignored in IDLE.
- SHIFT:
  - busy=1, out_valid=1.
  - out = sreg[N-1] when MSB_FIRST=1, else sreg[0].
  - The first bit appears the cycle after the handshake, i.e. latency 1 clk from accept to first bit.
- Shift on ena=1 with cnt<N-1:
  - sreg shifts toward the output end by one position, zero-filled.
  - cnt<=cnt+1.
- ena=0 in SHIFT: sreg, cnt and out hold. The bit stays on out indefinitely.
- Last bit (ena=1 and cnt==N-1):
  - done<=1 on the next cycle, for exactly 1 clk.
  - If in_valid=1 in that same cycle: load the new word, cnt<=0, remain in SHIFT. This gives gapless back-to-back streaming with no idle bit between words.
  - Otherwise go to IDLE.
- in_ready:
  - Combinational: in_ready = (state==IDLE) | (state==SHIFT & cnt==N-1 & ena).
  - in_valid while in_ready=0 is ignored; in_data is not sampled.
  - A producer must hold in_valid and in_data until in_ready is seen.
- Serial bit timing: each bit stays on out from one enabled edge to the next. The receiver samples it on the next ena edge.
- N=1:
  - cnt is constant 0.
  - Every enabled SHIFT cycle is a last-bit cycle.
  - Back-to-back loads are still supported.
- done and in_ready may both be high in the same cycle, when the previous word finishes and the next is accepted.

Test Plan:
- N=8, MSB_FIRST=1, ena=1 always, load 0xA5 -> out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; out_valid high for exactly 8 cycles; done pulses once, the cycle after the 8th bit; out returns to IDLE_LEVEL.
- Loopback: this block's out drives a same-N SIPO receiver on shared ena, 1-in-3 duty, words 0x3C then 0x81 -> receiver parallel output equals 0x3C after 8 enabled edges, then 0x81; each bit held 3 clks.
- Back-to-back: in_valid held high with 0x3C then 0xC3, ena=1 -> 16 contiguous bits 00111100_11000011 with no idle gap; in_ready high only on the last-bit cycle; two done pulses 8 clks apart.
- Protocol: in_valid pulsed with 0xFF while busy and cnt<7 -> word ignored, output stream unchanged; ena=0 for 5 clks mid-word -> out and cnt frozen.
- Reset mid-word: assert rst low asynchronously after 3 bits of 0xA5 -> immediately out=IDLE_LEVEL, busy=0, out_valid=0; no done pulse; after release, a new load of 0x5A transmits correctly.
- MSB_FIRST=0, N=4, load 0x1 -> out = 1,0,0,0. Also N=1 streaming 1,0,1 back-to-back -> one done pulse per bit.
